sequential_alu_unit: RTL



---
 rtl/sequential_alu_unit.sv | 137 +++++++++++++
 1 files changed

// File: rtl/sequential_alu_unit.sv
// sequential_alu_unit: one-cycle AND/OR/NOR/ADD/SUB/LUI, bit-serial SLL/SRL; done one cycle after accept, or after shamt SHIFT cycles.
// start is sampled only in IDLE and never queued; define ALU_OVERFLOW_EN to enable the signed overflow flag.
module sequential_alu_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [3:0]             alu_operation,
    input  logic [SHAMT_WIDTH-1:0] shamt,
    input  logic [DATA_WIDTH-1:0]  a_data,
    input  logic [DATA_WIDTH-1:0]  b_data,
    output logic                   busy,
    output logic                   done,
    output logic [DATA_WIDTH-1:0]  result,
    output logic                   zero,
    output logic                   op_error,
    output logic                   overflow
);
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_NOR = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_LUI = 4'b0101;
    localparam logic [3:0] OP_SLL = 4'b0110;
    localparam logic [3:0] OP_SRL = 4'b0111;
    localparam int         MSB    = DATA_WIDTH - 1;
    localparam int         HALF   = DATA_WIDTH / 2;

    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

    state_t                 state, state_next;
    logic [DATA_WIDTH-1:0]  work, work_shifted, imm_result, sum, diff;
    logic [SHAMT_WIDTH-1:0] count;
    logic                   shift_left, imm_error, long_shift, accept, last_shift;

    assign sum          = a_data + b_data;
    assign diff         = a_data - b_data;
    assign accept       = (state == IDLE) && start;
    assign long_shift   = ((alu_operation == OP_SLL) || (alu_operation == OP_SRL)) && (shamt != '0);
    assign last_shift   = (state == SHIFT) && (count == SHAMT_WIDTH'(1));
    assign work_shifted = shift_left ? (work << 1) : (work >> 1);

    // Single-cycle result; a zero-length shift simply passes A through.
    always_comb begin
        imm_result = '0;
        imm_error  = 1'b0;
        case (alu_operation)
            OP_AND:         imm_result = a_data & b_data;
            OP_OR:          imm_result = a_data | b_data;
            OP_NOR:         imm_result = ~(a_data | b_data);
            OP_ADD:         imm_result = sum;
            OP_SUB:         imm_result = diff;
            OP_LUI:         imm_result = {b_data[HALF-1:0], {HALF{1'b0}}};
            OP_SLL, OP_SRL: imm_result = a_data;
            default:        imm_error  = 1'b1;
        endcase
    end

`ifdef ALU_OVERFLOW_EN
    logic imm_ovf, ovf_q;

    always_comb begin
        imm_ovf = 1'b0;
        if (alu_operation == OP_ADD)
            imm_ovf = (a_data[MSB] == b_data[MSB]) && (sum[MSB] != a_data[MSB]);
        else if (alu_operation == OP_SUB)
            imm_ovf = (a_data[MSB] != b_data[MSB]) && (diff[MSB] != a_data[MSB]);
    end

    always_ff @(posedge clk) begin
        if (!reset)
            ovf_q <= 1'b0;
        else if (accept && !long_shift)
            ovf_q <= imm_ovf;
        else if (last_shift)
            ovf_q <= 1'b0;
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = long_shift ? SHIFT : DONE;
            SHIFT:   if (count == SHAMT_WIDTH'(1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            work       <= '0;
            count      <= '0;
            shift_left <= 1'b0;
            result     <= '0;
            zero       <= 1'b0;
            op_error   <= 1'b0;
        end else if (accept) begin
            if (long_shift) begin
                work       <= a_data;
                count      <= shamt;
                shift_left <= (alu_operation == OP_SLL);
            end else begin
                result   <= imm_result;
                zero     <= (imm_result == '0);
                op_error <= imm_error;
            end
        end else if (state == SHIFT) begin
            work  <= work_shifted;
            count <= count - 1'b1;
            if (last_shift) begin
                result   <= work_shifted;
                zero     <= (work_shifted == '0);
                op_error <= 1'b0;
            end
        end
    end
endmodule
